// File: rtl/mpu_pkg.sv
// Shared types and widths for the MPU memory arbiter.
// PortIdW must equal clog2(NUM_PORTS) of the arbiter instance.
package mpu_pkg;

  localparam int PortIdW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_t;

endpackage

// File: rtl/mpu_mem_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
module rr_priority_pick
  import mpu_pkg::*;
#(
  parameter int N   = 4,
  parameter int IdW = PortIdW
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic           found,
  output logic [IdW-1:0] idx
);

  logic [IdW:0] cand;

  // Scan farthest-first so the candidate nearest the pointer wins.
  always_comb begin
    found = |req;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IdW + 1)'(k);
      if (cand >= (IdW + 1)'(N)) cand = cand - (IdW + 1)'(N);
      if (req[cand[IdW-1:0]]) idx = cand[IdW-1:0];
    end
  end

endmodule

// File: rtl/mpu_mem_arbiter.sv
// Round-robin arbiter sharing one HBM read/write channel between NUM_PORTS MPUs,
// one transaction outstanding at a time.
module mpu_mem_arbiter
  import mpu_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int AddrWidth = 33,
  parameter int DataWidth = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           p_start_rd,
  input  logic [NUM_PORTS-1:0]           p_start_wr,
  input  logic [NUM_PORTS*AddrWidth-1:0] p_read_addr,
  input  logic [NUM_PORTS*AddrWidth-1:0] p_write_addr,
  input  logic [NUM_PORTS*DataWidth-1:0] p_write_data,
  output logic [NUM_PORTS-1:0]           p_end_rd,
  output logic [NUM_PORTS-1:0]           p_end_wr,
  output logic [DataWidth-1:0]           p_read_data,
  output logic [AddrWidth-1:0]           m_addr,
  output logic [DataWidth-1:0]           m_write_data,
  output logic                           m_start_rd,
  output logic                           m_start_wr,
  input  logic                           m_end_rd,
  input  logic                           m_end_wr,
  input  logic [DataWidth-1:0]           m_read_data,
  output logic                           busy,
  output logic [PortIdW-1:0]             grant_id,
  output logic [NUM_PORTS-1:0]           req_overflow
);

  state_t state, next_state;
  req_t   gnt_type;

  logic [PortIdW-1:0]   ptr;
  logic [PortIdW-1:0]   pick_idx;
  logic                 pick_found;
  logic                 grant_now;
  logic                 done_now;
  logic [NUM_PORTS-1:0] rd_pend;
  logic [NUM_PORTS-1:0] wr_pend;
  logic [NUM_PORTS-1:0] gnt_onehot;
  logic [NUM_PORTS-1:0] clr_rd;
  logic [NUM_PORTS-1:0] clr_wr;

  logic [AddrWidth-1:0] rd_addr_q [NUM_PORTS];
  logic [AddrWidth-1:0] wr_addr_q [NUM_PORTS];
  logic [DataWidth-1:0] wr_data_q [NUM_PORTS];

  rr_priority_pick #(
    .N   (NUM_PORTS),
    .IdW (PortIdW)
  ) u_pick (
    .req   (rd_pend | wr_pend),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign gnt_onehot = NUM_PORTS'(1) << grant_id;
  assign m_start_rd = (state == ISSUE) && (gnt_type == REQ_RD);
  assign m_start_wr = (state == ISSUE) && (gnt_type == REQ_WR);
  assign busy       = (state != IDLE);
  assign clr_rd     = m_start_rd ? gnt_onehot : '0;
  assign clr_wr     = m_start_wr ? gnt_onehot : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_now  = 1'b0;
    done_now   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          next_state = ISSUE;
          grant_now  = 1'b1;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if ((gnt_type == REQ_RD && m_end_rd) || (gnt_type == REQ_WR && m_end_wr)) begin
          next_state = IDLE;
          done_now   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A new pulse beats the grant-side clear, so a re-request during ISSUE survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend      <= '0;
      wr_pend      <= '0;
      req_overflow <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_addr_q[i] <= '0;
        wr_addr_q[i] <= '0;
        wr_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if ((p_start_rd[i] && rd_pend[i]) || (p_start_wr[i] && wr_pend[i]))
          req_overflow[i] <= 1'b1;
        if (p_start_rd[i]) begin
          rd_pend[i]   <= 1'b1;
          rd_addr_q[i] <= p_read_addr[i*AddrWidth +: AddrWidth];
        end else if (clr_rd[i]) begin
          rd_pend[i] <= 1'b0;
        end
        if (p_start_wr[i]) begin
          wr_pend[i]   <= 1'b1;
          wr_addr_q[i] <= p_write_addr[i*AddrWidth +: AddrWidth];
          wr_data_q[i] <= p_write_data[i*DataWidth +: DataWidth];
        end else if (clr_wr[i]) begin
          wr_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Grant loads the memory channel; completion returns data and advances the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id     <= '0;
      gnt_type     <= REQ_RD;
      ptr          <= '0;
      m_addr       <= '0;
      m_write_data <= '0;
      p_read_data  <= '0;
      p_end_rd     <= '0;
      p_end_wr     <= '0;
    end else begin
      p_end_rd <= '0;
      p_end_wr <= '0;
      if (grant_now) begin
        grant_id     <= pick_idx;
        gnt_type     <= rd_pend[pick_idx] ? REQ_RD : REQ_WR;
        m_addr       <= rd_pend[pick_idx] ? rd_addr_q[pick_idx] : wr_addr_q[pick_idx];
        m_write_data <= wr_data_q[pick_idx];
      end
      if (done_now) begin
        ptr <= (grant_id == PortIdW'(NUM_PORTS - 1)) ? '0 : grant_id + 1'b1;
        if (gnt_type == REQ_RD) begin
          p_read_data <= m_read_data;
          p_end_rd    <= gnt_onehot;
        end else begin
          p_end_wr <= gnt_onehot;
        end
      end
    end
  end

endmodule

// File: tb/tb_mpu_mem_arbiter.sv
// Directed self-checking bench for mpu_mem_arbiter; all outputs are sampled on the falling edge.
module tb_mpu_mem_arbiter;

  localparam int NP = 4;
  localparam int AW = 33;
  localparam int DW = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NP-1:0]     p_start_rd = '0;
  logic [NP-1:0]     p_start_wr = '0;
  logic [NP*AW-1:0]  p_read_addr = '0;
  logic [NP*AW-1:0]  p_write_addr = '0;
  logic [NP*DW-1:0]  p_write_data = '0;
  logic [NP-1:0]     p_end_rd;
  logic [NP-1:0]     p_end_wr;
  logic [DW-1:0]     p_read_data;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_write_data;
  logic              m_start_rd;
  logic              m_start_wr;
  logic              m_end_rd = 1'b0;
  logic              m_end_wr = 1'b0;
  logic [DW-1:0]     m_read_data = '0;
  logic              busy;
  logic [1:0]        grant_id;
  logic [NP-1:0]     req_overflow;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  mpu_mem_arbiter #(
    .NUM_PORTS (NP),
    .AddrWidth (AW),
    .DataWidth (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .p_start_rd   (p_start_rd),
    .p_start_wr   (p_start_wr),
    .p_read_addr  (p_read_addr),
    .p_write_addr (p_write_addr),
    .p_write_data (p_write_data),
    .p_end_rd     (p_end_rd),
    .p_end_wr     (p_end_wr),
    .p_read_data  (p_read_data),
    .m_addr       (m_addr),
    .m_write_data (m_write_data),
    .m_start_rd   (m_start_rd),
    .m_start_wr   (m_start_wr),
    .m_end_rd     (m_end_rd),
    .m_end_wr     (m_end_wr),
    .m_read_data  (m_read_data),
    .busy         (busy),
    .grant_id     (grant_id),
    .req_overflow (req_overflow)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic setRead(input int p, input logic [AW-1:0] a);
    p_start_rd[p] = 1'b1;
    p_read_addr[p*AW +: AW] = a;
  endtask

  task automatic setWrite(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_start_wr[p] = 1'b1;
    p_write_addr[p*AW +: AW] = a;
    p_write_data[p*DW +: DW] = d;
  endtask

  // Holds the staged pulses for exactly one clock edge.
  task automatic applyStimulus();
    tick();
    p_start_rd = '0;
    p_start_wr = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    p_start_rd = '0;
    p_start_wr = '0;
    m_end_rd = 1'b0;
    m_end_wr = 1'b0;
    m_read_data = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Waits (bounded) for the memory start pulse and checks the granted transaction.
  task automatic expectStart(input string tag, input bit isWr, input int port,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             output int waited);
    waited = 0;
    while (!(m_start_rd || m_start_wr) && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_started"}, DW'(m_start_rd || m_start_wr), DW'(1));
    if (m_start_rd || m_start_wr) begin
      checkOutput({tag, "_start_rd"}, DW'(m_start_rd), DW'(!isWr));
      checkOutput({tag, "_start_wr"}, DW'(m_start_wr), DW'(isWr));
      checkOutput({tag, "_addr"}, DW'(m_addr), DW'(addr));
      checkOutput({tag, "_grant"}, DW'(grant_id), DW'(port));
      checkOutput({tag, "_busy_issue"}, DW'(busy), DW'(1));
      if (isWr) checkOutput({tag, "_wdata"}, m_write_data, wdata);
    end
  endtask

  // Completes the in-flight transaction, optionally after a wrong-type end pulse.
  task automatic finishTxn(input string tag, input bit isWr, input int port,
                           input logic [DW-1:0] rdata, input bit wrongFirst);
    logic [NP-1:0] oneHot;
    oneHot = NP'(1) << port;
    tick();
    checkOutput({tag, "_start_single"}, DW'({m_start_rd, m_start_wr}), DW'(0));
    checkOutput({tag, "_busy_wait"}, DW'(busy), DW'(1));
    if (wrongFirst) begin
      if (isWr) m_end_rd = 1'b1; else m_end_wr = 1'b1;
      tick();
      m_end_rd = 1'b0;
      m_end_wr = 1'b0;
      checkOutput({tag, "_wrong_end_rd"}, DW'(p_end_rd), DW'(0));
      checkOutput({tag, "_wrong_end_wr"}, DW'(p_end_wr), DW'(0));
      checkOutput({tag, "_wrong_busy"}, DW'(busy), DW'(1));
    end
    if (isWr) m_end_wr = 1'b1;
    else begin
      m_end_rd = 1'b1;
      m_read_data = rdata;
    end
    tick();
    m_end_rd = 1'b0;
    m_end_wr = 1'b0;
    m_read_data = '1;
    checkOutput({tag, "_p_end_rd"}, DW'(p_end_rd), isWr ? DW'(0) : DW'(oneHot));
    checkOutput({tag, "_p_end_wr"}, DW'(p_end_wr), isWr ? DW'(oneHot) : DW'(0));
    if (!isWr) checkOutput({tag, "_rdata"}, p_read_data, rdata);
    checkOutput({tag, "_busy_done"}, DW'(busy), DW'(0));
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    checkOutput("rst_busy", DW'(busy), DW'(0));
    checkOutput("rst_grant", DW'(grant_id), DW'(0));
    checkOutput("rst_start", DW'({m_start_rd, m_start_wr}), DW'(0));
    checkOutput("rst_addr", DW'(m_addr), DW'(0));
    checkOutput("rst_p_end", DW'({p_end_rd, p_end_wr}), DW'(0));
    checkOutput("rst_rdata", p_read_data, DW'(0));
    checkOutput("rst_overflow", DW'(req_overflow), DW'(0));

    // Single read on port 2: start two cycles after the pulse
    setRead(2, 33'h100);
    applyStimulus();
    expectStart("single", 1'b0, 2, 33'h100, '0, lat);
    checkOutput("single_latency", DW'(lat), DW'(1));
    finishTxn("single", 1'b0, 2, DW'(256'hABCD), 1'b0);

    // Four simultaneous reads from pointer 0
    doReset();
    for (int i = 0; i < NP; i++) setRead(i, AW'(33'h1000 + i));
    applyStimulus();
    for (int i = 0; i < NP; i++) begin
      expectStart($sformatf("simul%0d", i), 1'b0, i, AW'(33'h1000 + i), '0, lat);
      checkOutput($sformatf("simul%0d_latency", i), DW'(lat), DW'(1));
      finishTxn($sformatf("simul%0d", i), 1'b0, i, DW'(256'h5000 + i), 1'b0);
    end
    tick();
    checkOutput("simul_idle_busy", DW'(busy), DW'(0));
    checkOutput("simul_idle_start", DW'({m_start_rd, m_start_wr}), DW'(0));

    // Fairness: port 0 re-requests right after completion, port 3 still wins next
    doReset();
    setRead(0, 33'h40);
    setRead(3, 33'h43);
    applyStimulus();
    expectStart("fair_p0a", 1'b0, 0, 33'h40, '0, lat);
    finishTxn("fair_p0a", 1'b0, 0, DW'(256'h10), 1'b0);
    setRead(0, 33'h41);
    applyStimulus();
    expectStart("fair_p3", 1'b0, 3, 33'h43, '0, lat);
    finishTxn("fair_p3", 1'b0, 3, DW'(256'h13), 1'b0);
    expectStart("fair_p0b", 1'b0, 0, 33'h41, '0, lat);
    finishTxn("fair_p0b", 1'b0, 0, DW'(256'h11), 1'b0);

    // Port 1 read and write together, port 2 read in between; wrap on pointer
    doReset();
    setRead(1, 33'h200);
    setWrite(1, 33'h200, DW'(256'h55));
    setRead(2, 33'h280);
    applyStimulus();
    expectStart("rw_rd1", 1'b0, 1, 33'h200, '0, lat);
    finishTxn("rw_rd1", 1'b0, 1, DW'(256'h77), 1'b0);
    expectStart("rw_rd2", 1'b0, 2, 33'h280, '0, lat);
    finishTxn("rw_rd2", 1'b0, 2, DW'(256'h88), 1'b0);
    expectStart("rw_wr1", 1'b1, 1, 33'h200, DW'(256'h55), lat);
    finishTxn("rw_wr1", 1'b1, 1, '0, 1'b1);
    checkOutput("rw_rdata_hold", p_read_data, DW'(256'h88));

    // Overflow: port 3 pulses twice while port 0 is in flight
    doReset();
    setRead(0, 33'h300);
    applyStimulus();
    expectStart("ovf_p0", 1'b0, 0, 33'h300, '0, lat);
    setRead(3, 33'h10);
    applyStimulus();
    checkOutput("ovf_flag_first", DW'(req_overflow), DW'(0));
    setRead(3, 33'h20);
    applyStimulus();
    checkOutput("ovf_flag", DW'(req_overflow), DW'(4'b1000));
    finishTxn("ovf_p0", 1'b0, 0, DW'(256'h30), 1'b0);
    expectStart("ovf_p3", 1'b0, 3, 33'h20, '0, lat);
    finishTxn("ovf_p3", 1'b0, 3, DW'(256'h33), 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("ovf_no_dup%0d", i), DW'({m_start_rd, m_start_wr, busy}), DW'(0));
    end
    checkOutput("ovf_sticky", DW'(req_overflow), DW'(4'b1000));

    // Reset while port 1's read is in flight, then a late m_end_rd
    doReset();
    setRead(1, 33'h111);
    setRead(2, 33'h222);
    applyStimulus();
    expectStart("rstw", 1'b0, 1, 33'h111, '0, lat);
    tick();
    checkOutput("rstw_in_wait", DW'(busy), DW'(1));
    reset = 1'b1;
    #1;
    checkOutput("rstw_async_busy", DW'(busy), DW'(0));
    tick();
    checkOutput("rstw_outputs", DW'({busy, grant_id, m_start_rd, m_start_wr, p_end_rd, p_end_wr}), DW'(0));
    checkOutput("rstw_addr", DW'(m_addr), DW'(0));
    reset = 1'b0;
    tick();
    m_end_rd = 1'b1;
    m_read_data = DW'(256'hDEAD);
    tick();
    m_end_rd = 1'b0;
    checkOutput("rstw_late_end", DW'(p_end_rd), DW'(0));
    checkOutput("rstw_rdata", p_read_data, DW'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rstw_idle%0d", i), DW'({m_start_rd, m_start_wr, busy}), DW'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
